// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding select generator and load-use stall controller.
// Latency: fwd_sel_a/b registered, valid one cycle after ID (while the instruction is in EX); stall is combinational.
// Backpressure: hold freezes every register; flush or stall pushes a bubble into EX and clears the selects.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   hold                 global freeze, all state keeps its value
//   flush                discard the instruction in ID (branch redirect)
//   id_*                 decoded fields of the instruction currently in ID
//   stall                freeze PC/IF/ID and insert a bubble into EX (combinational)
//   fwd_sel_a/b          EX operand mux selects: 00 RF, 01 EX/MEM ALU, 10 MEM/WB, 11 immediate (B only)
//   stall_count          saturating count of load-use stalls

module fwd_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_use_imm_b,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  output logic                  stall,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // Tag of the instruction now in EX.
  logic                  ex_v_q,  ex_v_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_wr_q, ex_wr_d;
  logic                  ex_ld_q, ex_ld_d;

  // Tag of the instruction now in MEM. Load-ness is irrelevant here: MEM/WB data is ready.
  logic                  mem_v_q,  mem_v_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_wr_q, mem_wr_d;

  logic [1:0]            sel_a_q, sel_a_d;
  logic [1:0]            sel_b_q, sel_b_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;

  // Source qualification: x0 is hard-wired zero, so it never matches a producer.
  logic rs1_live, rs2_live;
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic [1:0] sel_a_c, sel_b_c;
  logic load_use;

  always_comb begin
    rs1_live = id_rs1_used && (id_rs1 != '0);
    rs2_live = id_rs2_used && (id_rs2 != '0);

    ex_hit1  = rs1_live && ex_v_q  && ex_wr_q  && (ex_rd_q  == id_rs1);
    ex_hit2  = rs2_live && ex_v_q  && ex_wr_q  && (ex_rd_q  == id_rs2);
    mem_hit1 = rs1_live && mem_v_q && mem_wr_q && (mem_rd_q == id_rs1);
    mem_hit2 = rs2_live && mem_v_q && mem_wr_q && (mem_rd_q == id_rs2);
  end

  // Youngest producer wins: EX before MEM. A WB-stage producer needs nothing
  // because the register file writes before it reads.
  always_comb begin
    sel_a_c = SEL_RF;
    if (ex_hit1) begin
      sel_a_c = SEL_EX;
    end else if (mem_hit1) begin
      sel_a_c = SEL_MEM;
    end

    sel_b_c = SEL_RF;
    if (id_use_imm_b) begin
      sel_b_c = SEL_IMM;
    end else if (ex_hit2) begin
      sel_b_c = SEL_EX;
    end else if (mem_hit2) begin
      sel_b_c = SEL_MEM;
    end
  end

  // A load in EX has no data until MEM, so a direct consumer must wait one cycle.
  // Operand B only counts when it is a register operand.
  always_comb begin
    load_use = ex_ld_q && (ex_hit1 || (ex_hit2 && !id_use_imm_b));
    stall    = id_valid && !flush && load_use;
  end

  // Next-state selection; rows are prioritised rst > hold > bubble > advance.
  always_comb begin
    ex_v_d   = ex_v_q;
    ex_rd_d  = ex_rd_q;
    ex_wr_d  = ex_wr_q;
    ex_ld_d  = ex_ld_q;
    mem_v_d  = mem_v_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    cnt_d    = cnt_q;

    if (rst) begin
      ex_v_d   = 1'b0;
      ex_rd_d  = '0;
      ex_wr_d  = 1'b0;
      ex_ld_d  = 1'b0;
      mem_v_d  = 1'b0;
      mem_rd_d = '0;
      mem_wr_d = 1'b0;
      sel_a_d  = SEL_RF;
      sel_b_d  = SEL_RF;
      cnt_d    = '0;
    end else if (hold) begin
      // everything keeps its value
    end else if (flush || stall) begin
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_wr_d = ex_wr_q;
      ex_v_d   = 1'b0;
      ex_rd_d  = '0;
      ex_wr_d  = 1'b0;
      ex_ld_d  = 1'b0;
      sel_a_d  = SEL_RF;
      sel_b_d  = SEL_RF;
      // stall is already forced low by flush, so only true load-use events count
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_wr_d = ex_wr_q;
      ex_v_d   = id_valid;
      ex_rd_d  = id_rd;
      ex_wr_d  = id_reg_write && id_valid;
      ex_ld_d  = id_is_load && id_valid;
      sel_a_d  = id_valid ? sel_a_c : SEL_RF;
      sel_b_d  = id_valid ? sel_b_c : SEL_RF;
    end
  end

  always_ff @(posedge clk) begin
    ex_v_q   <= ex_v_d;
    ex_rd_q  <= ex_rd_d;
    ex_wr_q  <= ex_wr_d;
    ex_ld_q  <= ex_ld_d;
    mem_v_q  <= mem_v_d;
    mem_rd_q <= mem_rd_d;
    mem_wr_q <= mem_wr_d;
    sel_a_q  <= sel_a_d;
    sel_b_q  <= sel_b_d;
    cnt_q    <= cnt_d;
  end

  assign fwd_sel_a   = sel_a_q;
  assign fwd_sel_b   = sel_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: directed test-plan steps followed by random traffic,
// checked against an instruction-history reference model. A second instance with a
// 2-bit counter receives the same stimulus to exercise counter saturation.

module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst, hold, flush;
  logic       id_valid, id_rs1_used, id_rs2_used, id_use_imm_b, id_reg_write, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall,  stall2;
  logic [1:0]  sel_a,  sel_b, sel_a2, sel_b2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_use_imm_b(id_use_imm_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .stall(stall), .fwd_sel_a(sel_a), .fwd_sel_b(sel_b), .stall_count(cnt)
  );

  fwd_hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_use_imm_b(id_use_imm_b), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .stall(stall2), .fwd_sel_a(sel_a2), .fwd_sel_b(sel_b2), .stall_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: history of instructions that entered EX, youngest first.
  // hist[0] is in EX, hist[1] is in MEM; bubbles have v=0.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } instr_t;

  instr_t hist[$];
  int     m_sa, m_sb, m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.v = 0; b.rd = 0; b.wr = 0; b.ld = 0;
    return b;
  endfunction

  // Where a source value comes from: 1 = EX producer, 2 = MEM producer, 0 = register file.
  function automatic int src_of(input logic [4:0] s, input logic used);
    if (!used || s == 0) return 0;
    for (int i = 0; i < 2; i++)
      if (hist[i].v && hist[i].wr && hist[i].rd == s) return i + 1;
    return 0;
  endfunction

  function automatic logic model_stall();
    logic need_a, need_b;
    need_a = (src_of(id_rs1, id_rs1_used) == 1);
    need_b = !id_use_imm_b && (src_of(id_rs2, id_rs2_used) == 1);
    return id_valid && !flush && hist[0].ld && (need_a || need_b);
  endfunction

  task automatic model_edge(input logic st);
    instr_t n;
    if (rst) begin
      hist.delete();
      hist.push_back(bubble());
      hist.push_back(bubble());
      m_sa = 0; m_sb = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (hold) begin
      // frozen
    end else if (flush || st) begin
      hist.push_front(bubble());
      void'(hist.pop_back());
      m_sa = 0; m_sb = 0;
      if (st) begin
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt2 < 3)     m_cnt2++;
      end
    end else begin
      if (id_valid) begin
        m_sa = src_of(id_rs1, id_rs1_used);
        m_sb = id_use_imm_b ? 3 : src_of(id_rs2, id_rs2_used);
      end else begin
        m_sa = 0; m_sb = 0;
      end
      n.v  = id_valid;
      n.rd = id_rd;
      n.wr = id_valid && id_reg_write;
      n.ld = id_valid && id_is_load;
      hist.push_front(n);
      void'(hist.pop_back());
    end
  endtask

  // One clock: check combinational stall, take the edge, advance model, check registers.
  task automatic cyc();
    logic st;
    #1;
    st = model_stall();
    chk("stall", {31'b0, stall}, {31'b0, st});
    chk("stall2", {31'b0, stall2}, {31'b0, st});
    @(posedge clk);
    model_edge(st);
    #1;
    chk("sel_a",  {30'b0, sel_a},  m_sa);
    chk("sel_b",  {30'b0, sel_b},  m_sb);
    chk("sel_a2", {30'b0, sel_a2}, m_sa);
    chk("sel_b2", {30'b0, sel_b2}, m_sb);
    chk("cnt",    {16'b0, cnt},    m_cnt);
    chk("cnt2",   {30'b0, cnt2},   m_cnt2);
  endtask

  task automatic set_i(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic imm,
                       input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_use_imm_b = imm; id_rd = rd; id_reg_write = wr; id_is_load = ld;
  endtask

  task automatic nop();
    set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    hist.push_back(bubble());
    hist.push_back(bubble());
    m_sa = 0; m_sb = 0; m_cnt = 0; m_cnt2 = 0;
    rst = 1; hold = 0; flush = 0;
    nop();

    // Reset state
    cyc(); cyc();
    chk("rst_sel_a", {30'b0, sel_a}, 0);
    chk("rst_sel_b", {30'b0, sel_b}, 0);
    chk("rst_cnt",   {16'b0, cnt},   0);
    chk("rst_stall", {31'b0, stall}, 0);
    rst = 0;

    // EX forward: add x5 ; sub x9, x5, x6
    set_i(1, 1, 1, 2, 1, 0, 5, 1, 0); cyc();
    set_i(1, 5, 1, 6, 1, 0, 9, 1, 0); cyc();
    chk("ex_fwd_a", {30'b0, sel_a}, 1);
    chk("ex_fwd_b", {30'b0, sel_b}, 0);

    // MEM forward: add x7 ; nop ; use x7
    set_i(1, 1, 1, 2, 1, 0, 7, 1, 0); cyc();
    nop(); cyc();
    set_i(1, 7, 1, 0, 0, 0, 8, 1, 0); cyc();
    chk("mem_fwd_a", {30'b0, sel_a}, 2);

    // Priority: add x7 ; add x7 ; use x7 -> youngest
    set_i(1, 1, 1, 2, 1, 0, 7, 1, 0); cyc();
    set_i(1, 1, 1, 2, 1, 0, 7, 1, 0); cyc();
    set_i(1, 7, 1, 0, 0, 0, 8, 1, 0); cyc();
    chk("prio_a", {30'b0, sel_a}, 1);

    // Load-use on rs2
    set_i(1, 1, 1, 0, 0, 1, 3, 1, 1); cyc();
    set_i(1, 1, 1, 3, 1, 0, 10, 1, 0);
    #1 chk("lu_stall", {31'b0, stall}, 1);
    cyc();
    chk("lu_cnt", {16'b0, cnt}, 1);
    #1 chk("lu_restall", {31'b0, stall}, 0);
    cyc();
    chk("lu_sel_b", {30'b0, sel_b}, 2);

    // x0 is never forwarded
    set_i(1, 1, 1, 0, 0, 1, 0, 1, 1); cyc();
    set_i(1, 0, 1, 0, 1, 0, 6, 1, 0);
    #1 chk("x0_stall", {31'b0, stall}, 0);
    cyc();
    chk("x0_sel_a", {30'b0, sel_a}, 0);
    chk("x0_sel_b", {30'b0, sel_b}, 0);

    // Immediate operand B masks load-use on rs2 field
    set_i(1, 1, 1, 0, 0, 1, 4, 1, 1); cyc();
    set_i(1, 1, 1, 4, 1, 1, 11, 1, 0);
    #1 chk("imm_stall", {31'b0, stall}, 0);
    cyc();
    chk("imm_sel_b", {30'b0, sel_b}, 3);

    // Flush dominates a load-use pattern
    set_i(1, 1, 1, 0, 0, 1, 3, 1, 1); cyc();
    set_i(1, 3, 1, 0, 0, 0, 12, 1, 0); flush = 1;
    #1 chk("fl_stall", {31'b0, stall}, 0);
    cyc();
    flush = 0;
    chk("fl_cnt",   {16'b0, cnt},   1);
    chk("fl_sel_a", {30'b0, sel_a}, 0);

    // Hold for 3 cycles mid-forwarding
    set_i(1, 1, 1, 2, 1, 0, 5, 1, 0); cyc();
    set_i(1, 5, 1, 0, 0, 0, 9, 1, 0); cyc();
    hold = 1;
    set_i(1, 0, 0, 0, 0, 0, 13, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_sel_a", {30'b0, sel_a}, 1);
    end
    hold = 0;
    set_i(1, 5, 1, 9, 1, 0, 14, 1, 0); cyc();
    chk("post_hold_a", {30'b0, sel_a}, 2);
    chk("post_hold_b", {30'b0, sel_b}, 1);

    // Reset mid-stream discards tags
    rst = 1; cyc(); rst = 0;
    chk("rst2_sel_a", {30'b0, sel_a}, 0);
    chk("rst2_cnt",   {16'b0, cnt},   0);
    set_i(1, 14, 1, 9, 1, 0, 15, 1, 0); cyc();
    chk("rst2_first_a", {30'b0, sel_a}, 0);
    chk("rst2_first_b", {30'b0, sel_b}, 0);

    // Five load-use stalls: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      set_i(1, 1, 1, 0, 0, 1, 3, 1, 1); cyc();
      set_i(1, 3, 1, 0, 0, 0, 16, 1, 0); cyc(); cyc();
    end
    chk("sat_cnt2", {30'b0, cnt2}, 3);
    chk("sat_cnt",  {16'b0, cnt},  5);

    // Random traffic; a stalled instruction is normally re-presented
    for (int t = 0; t < 600; t++) begin
      logic st_now;
      st_now = model_stall();
      if (!st_now || $urandom_range(0, 3) == 0) begin
        set_i($urandom_range(0, 5) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
              5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3) == 0,
              5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      end
      hold  = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 39) == 0);
      cyc();
    end
    rst = 0; hold = 0; flush = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Operand-forwarding and load-use hazard controller for the 5-stage pipeline. It tracks destination tags of in-flight instructions in EX and MEM. For each instruction leaving ID, it produces the registered 2-bit select codes that drive the two 32-bit 4:1 EX operand muxes. It also raises a one-cycle stall when a consumer directly follows a load.

## Interface
- `REG_ADDR_W`, 5, register-index width
- `CNT_W`, 16, width of stall-event counter
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `hold` in 1: global pipeline freeze (memory wait). All state holds.
- `flush` in 1: branch redirect. The instruction in ID is discarded.
- `id_valid` in 1: ID holds a real instruction
- `id_rs1`, `id_rs2` in REG_ADDR_W: source register indices
- `id_rs1_used`, `id_rs2_used` in 1: source is actually read
- `id_use_imm_b` in 1: operand B is the immediate
- `id_rd` in REG_ADDR_W: destination index
- `id_reg_write` in 1: instruction writes rd
- `id_is_load` in 1: instruction is a load
- `stall` out 1: combinational. Freeze PC/IF/ID and insert a bubble into EX.
- `fwd_sel_a` out 2: registered select for operand-A mux, valid while the instruction is in EX
- `fwd_sel_b` out 2: registered select for operand-B mux, same timing as `fwd_sel_a`
- `stall_count` out CNT_W: saturating count of load-use stalls

## Operation
- Select encoding: 00 = register-file read, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data, 11 = immediate.
  - 11 is generated only on B, and only when `id_use_imm_b`=1.
  - `fwd_sel_a` never takes 11.
- The register file is write-first, so a WB-stage writer needs no forwarding.
- Internal tags:
  - ex_tag {v, rd, wr, ld} describes the instruction now in EX.
  - mem_tag {v, rd, wr} describes the instruction now in MEM.
- Match conditions, evaluated per source s with `id_rsX_used`=1 and s≠0:
  - EX match: ex_tag.v & ex_tag.wr & ex_tag.rd==s.
  - MEM match: mem_tag.v & mem_tag.wr & mem_tag.rd==s.
- Select priority: EX match → 01 (youngest wins), else MEM match → 10, else 00.
- Register x0 is never forwarded and never stalls.
- `stall` = id_valid & ~flush & ex_tag.ld & (EX match on rs1, or EX match on rs2 with `id_use_imm_b`=0 and `id_rs2_used`=1).
- Per-edge update, first matching row wins:
  - `rst`: clear both tags, sels ← 00, `stall_count` ← 0.
  - `hold`: all registers keep their value.
  - `flush` or `stall`: ex_tag ← bubble (v=0), mem_tag ← ex_tag, sels ← 00.
    - On `stall` only, `stall_count` increments, saturating at all-ones.
  - Otherwise:
    - ex_tag ← {id_valid, id_rd, id_reg_write & id_valid, id_is_load & id_valid}.
    - mem_tag ← ex_tag.
    - Sels ← computed codes. If `id_valid`=0, sels ← 00.
- After a stall, the load has moved to MEM. The re-presented consumer therefore sees a MEM match and gets 10 with no second stall.
- `flush` dominates `stall`: no stall is counted while `flush`=1, and `stall` output is 0.

## Timing
- Reset values: `fwd_sel_a`=00, `fwd_sel_b`=00, `stall_count`=0, `stall`=0 (tags invalid).
- `stall` is combinational from ID inputs and ex_tag in the same cycle. It has no dependency on `hold`.
- Select latency is one cycle: codes computed in the ID cycle appear on `fwd_sel_*` at the next edge and stay stable through EX.
- A load-use stall lasts exactly one cycle.
- `hold` freezes tags, sels and counter for its full duration. Behaviour resumes unchanged when it deasserts.
- `rst` asserted mid-stream discards all in-flight tags. The first instruction after reset sees only 00/11 codes.

## Test plan
- **EX forward:** cycle 0 ID add x5 (wr); cycle 1 ID sub rs1=x5, rs2=x6.
  - Required: cycle 2 `fwd_sel_a`=01, `fwd_sel_b`=00, `stall`=0 throughout.
- **MEM forward and priority:**
  - add x7, then nop, then use x7 → `fwd_sel_a`=10.
  - add x7, add x7, use x7 → `fwd_sel_a`=01 (youngest wins).
- **Load-use:** lw x3; next ID uses rs2=x3 with `id_use_imm_b`=0.
  - Required: `stall`=1 for one cycle, `stall_count` 0→1.
  - On re-presentation: `stall`=0, then `fwd_sel_b`=10.
- **x0 and immediate:**
  - lw x0 followed by a use of x0 → no stall, sels 00.
  - lw x4 then addi with rs2 field=x4, `id_use_imm_b`=1, rs1=x1 → `stall`=0, `fwd_sel_b`=11.
- **Flush and hold:**
  - `flush` with a load-use pattern in ID → `stall`=0, counter unchanged, next sels 00.
  - `hold` for 3 cycles mid-forwarding → `fwd_sel_*` and tags unchanged.
  - `rst` pulsed after → all outputs 0.
- **Counter saturation:** with `CNT_W`=2, force 5 load-use stalls → `stall_count` ends at 3.
